// File: rtl/i2s_frame_scheduler.sv
// Paces stereo-frame pops from the CDC FIFO into the I2S serializer, with prime/underrun
// handling and a per-frame arithmetic-shift ramp for click-free mute and stop.
module i2s_frame_scheduler #(
   parameter int unsigned UNDERRUN_LIMIT   = 4,
   parameter int unsigned CNT_W            = 16,
   parameter bit          HOLD_ON_UNDERRUN = 1'b0
) (
   input  logic             aud_clk_i,
   input  logic             aud_rst_i,
   input  logic             enable_i,
   input  logic             mute_i,
   input  logic             clr_stat_i,
   input  logic [31:0]      fifo_data_i,
   input  logic             fifo_valid_i,
   output logic             fifo_ready_o,
   input  logic             frame_req_i,
   output logic [31:0]      audio_data_o,
   output logic             running_o,
   output logic [1:0]       state_o,
   output logic             underrun_o,
   output logic [CNT_W-1:0] underrun_cnt_o
);

   typedef enum logic [1:0] {StIdle = 2'd0, StPrime = 2'd1, StRun = 2'd2, StStop = 2'd3} state_e;

   state_e           state_q, state_d;
   logic [4:0]       shift_q, shift_d;
   logic [31:0]      last_q, last_d;
   logic [31:0]      data_q, data_d;
   logic [7:0]       consec_q, consec_d, consec_inc;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
   logic             sticky_q, sticky_d;
   logic [31:0]      raw;
   logic             pop, miss, evt, target_max, limit_hit;

   // Shift 16 is full silence; below that, a plain arithmetic shift per channel.
   function automatic logic [15:0] shr(input logic [15:0] s, input logic [4:0] sh);
      return sh[4] ? 16'h0 : 16'($signed(s) >>> sh[3:0]);
   endfunction

   assign pop        = frame_req_i && fifo_valid_i;
   assign miss       = frame_req_i && !fifo_valid_i;
   assign consec_inc = consec_q + 8'd1;
   assign limit_hit  = (state_q == StRun) && miss && (32'(consec_inc) >= UNDERRUN_LIMIT);

   // State register
   always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
      if (aud_rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (enable_i) state_d = StPrime;
         StPrime: begin
            if (pop)            state_d = enable_i ? StRun : StIdle;
            else if (!enable_i) state_d = StIdle;
         end
         StRun: begin
            if (!enable_i)      state_d = StStop;
            else if (limit_hit) state_d = StPrime;
         end
         StStop: begin
            if (enable_i)                                state_d = StRun;
            else if (frame_req_i && shift_d == 5'd16)    state_d = StIdle;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      fifo_ready_o = (state_q == StIdle) || pop;
      running_o    = (state_q == StRun);
      state_o      = state_q;
   end

   // Frame source selection, ramp target and underrun accounting
   always_comb begin
      raw        = 32'h0;
      last_d     = last_q;
      consec_d   = 8'h0;
      evt        = 1'b0;
      target_max = 1'b1;
      unique case (state_q)
         StPrime: begin
            if (pop) begin
               raw        = fifo_data_i;
               last_d     = fifo_data_i;
               target_max = mute_i;
            end
         end
         StRun, StStop: begin
            if (pop) begin
               raw    = fifo_data_i;
               last_d = fifo_data_i;
            end else if (miss && HOLD_ON_UNDERRUN) begin
               raw = last_q;
            end
            if (state_q == StRun) begin
               target_max = mute_i;
               evt        = miss;
               consec_d   = pop ? 8'h0 : (miss ? consec_inc : consec_q);
               if (limit_hit) consec_d = 8'h0;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      shift_d = shift_q;
      if (frame_req_i) begin
         if (target_max && shift_q != 5'd16)     shift_d = shift_q + 5'd1;
         else if (!target_max && shift_q != 5'd0) shift_d = shift_q - 5'd1;
      end
      data_d = frame_req_i ? {shr(raw[31:16], shift_d), shr(raw[15:0], shift_d)} : data_q;
   end

   // Clear applies before a same-cycle underrun so that event still counts.
   always_comb begin
      cnt_base = clr_stat_i ? '0 : cnt_q;
      cnt_d    = (evt && cnt_base != '1) ? cnt_base + CNT_W'(1) : cnt_base;
      sticky_d = (sticky_q && !clr_stat_i) || evt;
   end

   always_ff @(posedge aud_clk_i or posedge aud_rst_i) begin
      if (aud_rst_i) begin
         shift_q  <= 5'd16;
         last_q   <= 32'h0;
         data_q   <= 32'h0;
         consec_q <= 8'h0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
      end else begin
         shift_q  <= shift_d;
         last_q   <= last_d;
         data_q   <= data_d;
         consec_q <= consec_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
      end
   end

   assign audio_data_o   = data_q;
   assign underrun_o     = sticky_q;
   assign underrun_cnt_o = cnt_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench: two scheduler instances (silence/16-bit counter and hold/3-bit counter)
// share one random stimulus stream and are compared against a frame-level reference model.
module tb_i2s_frame_scheduler;

   localparam int ST_IDLE = 0, ST_PRIME = 1, ST_RUN = 2, ST_STOP = 3;

   typedef struct {
      logic [31:0] data;
      int          cnt;
      bit          sticky;
   } frame_t;

   logic        clk = 1'b0, rst = 1'b0;
   logic        enable = 1'b0, mute = 1'b0, clr_stat = 1'b0;
   logic        fifo_valid = 1'b0, frame_req = 1'b0;
   logic [31:0] fifo_data = 32'h0;

   logic        ready   [2];
   logic [31:0] dout    [2];
   logic        running [2];
   logic [1:0]  dstate  [2];
   logic        sticky  [2];
   logic [15:0] cnt_a;
   logic [2:0]  cnt_b;
   logic [15:0] dcnt    [2];

   assign dcnt[0] = cnt_a;
   assign dcnt[1] = {13'h0, cnt_b};

   always #5 clk = ~clk;

   i2s_frame_scheduler #(.UNDERRUN_LIMIT(4), .CNT_W(16), .HOLD_ON_UNDERRUN(1'b0)) dut_a (
      .aud_clk_i(clk), .aud_rst_i(rst), .enable_i(enable), .mute_i(mute),
      .clr_stat_i(clr_stat), .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid),
      .fifo_ready_o(ready[0]), .frame_req_i(frame_req), .audio_data_o(dout[0]),
      .running_o(running[0]), .state_o(dstate[0]), .underrun_o(sticky[0]),
      .underrun_cnt_o(cnt_a)
   );

   i2s_frame_scheduler #(.UNDERRUN_LIMIT(200), .CNT_W(3), .HOLD_ON_UNDERRUN(1'b1)) dut_b (
      .aud_clk_i(clk), .aud_rst_i(rst), .enable_i(enable), .mute_i(mute),
      .clr_stat_i(clr_stat), .fifo_data_i(fifo_data), .fifo_valid_i(fifo_valid),
      .fifo_ready_o(ready[1]), .frame_req_i(frame_req), .audio_data_o(dout[1]),
      .running_o(running[1]), .state_o(dstate[1]), .underrun_o(sticky[1]),
      .underrun_cnt_o(cnt_b)
   );

   int checks = 0, failures = 0;

   // Reference model state and per-instance configuration
   int          p_limit [2] = '{4, 200};
   int          p_cmax  [2] = '{65535, 7};
   bit          p_hold  [2] = '{1'b0, 1'b1};
   int          m_st    [2];
   int          m_shift [2];
   int          m_consec[2];
   int          m_cnt   [2];
   bit          m_sticky[2];
   logic [31:0] m_last  [2];
   frame_t      fq [2][$];
   int          sq [2][$];
   bit          s_en = 1'b0, s_mute = 1'b0;

   task automatic chk(input string name, input int i, input logic [31:0] got,
                      input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s[dut%0d] at %0t: got %h, want %h", name, i, $time, got, want);
      end
   endtask

   // Floor division by 2^sh on the signed sample; 16 or more means silence.
   function automatic logic [15:0] scale(input logic [15:0] v, input int sh);
      int s, d, r;
      if (sh >= 16) return 16'h0;
      s = int'($signed(v));
      d = 1 << sh;
      r = s / d;
      if (s < 0 && (s % d) != 0) r = r - 1;
      return r[15:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_st[i] = ST_IDLE; m_shift[i] = 16; m_consec[i] = 0;
         m_cnt[i] = 0; m_sticky[i] = 1'b0; m_last[i] = 32'h0;
         fq[i].delete(); sq[i].delete();
      end
   endtask

   task automatic model_step(input int i, input bit req, input bit valid,
                             input logic [31:0] data, input bit clr);
      logic [31:0] raw;
      bit          to_silence, underrun;
      int          nst;
      frame_t      f;
      raw = 32'h0; to_silence = 1'b1; underrun = 1'b0; nst = m_st[i];
      if (m_st[i] != ST_RUN) m_consec[i] = 0;
      case (m_st[i])
         ST_IDLE: if (s_en) nst = ST_PRIME;
         ST_PRIME: begin
            if (req && valid) begin
               raw = data; m_last[i] = data; to_silence = s_mute;
               nst = s_en ? ST_RUN : ST_IDLE;
            end else if (!s_en) nst = ST_IDLE;
         end
         ST_RUN: begin
            to_silence = s_mute;
            if (req && valid) begin
               raw = data; m_last[i] = data; m_consec[i] = 0;
            end else if (req) begin
               raw = p_hold[i] ? m_last[i] : 32'h0;
               m_consec[i]++; underrun = 1'b1;
            end
            if (!s_en) nst = ST_STOP;
            else if (m_consec[i] >= p_limit[i]) begin
               nst = ST_PRIME; m_consec[i] = 0;
            end
         end
         default: begin
            if (req && valid) begin
               raw = data; m_last[i] = data;
            end else if (req) raw = p_hold[i] ? m_last[i] : 32'h0;
         end
      endcase
      if (req) begin
         if (to_silence && m_shift[i] < 16) m_shift[i]++;
         else if (!to_silence && m_shift[i] > 0) m_shift[i]--;
      end
      if (m_st[i] == ST_STOP) begin
         if (s_en) nst = ST_RUN;
         else if (req && m_shift[i] == 16) nst = ST_IDLE;
      end
      if (clr) begin
         m_cnt[i] = 0; m_sticky[i] = 1'b0;
      end
      if (underrun) begin
         m_sticky[i] = 1'b1;
         if (m_cnt[i] < p_cmax[i]) m_cnt[i]++;
      end
      m_st[i] = nst;
      if (req) begin
         f.data   = {scale(raw[31:16], m_shift[i]), scale(raw[15:0], m_shift[i])};
         f.cnt    = m_cnt[i];
         f.sticky = m_sticky[i];
         fq[i].push_back(f);
      end
      sq[i].push_back(nst);
   endtask

   // One clock of stimulus: drive at negedge, check the combinational pop strobe, then
   // advance the model and queue what the next active edge must produce.
   task automatic step(input bit req, input bit valid, input logic [31:0] data, input bit clr);
      bit exp_ready;
      @(negedge clk);
      enable = s_en; mute = s_mute; clr_stat = clr;
      frame_req = req; fifo_valid = valid; fifo_data = data;
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_ready = (m_st[i] == ST_IDLE) || (req && valid);
         chk("fifo_ready", i, 32'(ready[i]), 32'(exp_ready));
         model_step(i, req, valid, data, clr);
      end
   endtask

   task automatic frame(input bit valid, input logic [31:0] data, input bit clr);
      int gap;
      gap = $urandom_range(1, 4);
      repeat (gap) step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);
      step(1'b1, valid, data, clr);
   endtask

   task automatic chk_reset_values();
      for (int i = 0; i < 2; i++) begin
         chk("rst_audio", i, dout[i], 32'h0);
         chk("rst_state", i, 32'(dstate[i]), 32'(ST_IDLE));
         chk("rst_running", i, 32'(running[i]), 32'h0);
         chk("rst_underrun", i, 32'(sticky[i]), 32'h0);
         chk("rst_cnt", i, 32'(dcnt[i]), 32'h0);
         chk("rst_ready", i, 32'(ready[i]), 32'h1);
      end
   endtask

   // Asynchronous reset landing between edges; outputs must clear without a clock.
   task automatic do_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      frame_req = 1'b0; enable = 1'b0; clr_stat = 1'b0;
      #1;
      chk_reset_values();
      model_reset();
      s_en = 1'b0; s_mute = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: pops the scoreboard whenever the DUT has taken a frame request.
   initial begin
      bit     req_s, rst_s;
      frame_t f;
      int     est;
      forever begin
         @(posedge clk);
         req_s = frame_req;
         rst_s = rst;
         #1;
         if (!rst_s) begin
            for (int i = 0; i < 2; i++) begin
               if (sq[i].size() > 0) begin
                  est = sq[i].pop_front();
                  chk("state", i, 32'(dstate[i]), 32'(est));
                  chk("running", i, 32'(running[i]), 32'(est == ST_RUN));
               end
               if (req_s) begin
                  if (fq[i].size() == 0) begin
                     checks++; failures++;
                     $display("FAIL frame_queue[dut%0d]: got a frame, want an expected entry", i);
                  end else begin
                     f = fq[i].pop_front();
                     chk("audio_data", i, dout[i], f.data);
                     chk("underrun_cnt", i, 32'(dcnt[i]), 32'(f.cnt));
                     chk("underrun", i, 32'(sticky[i]), 32'(f.sticky));
                  end
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 chk_reset_values();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Prime and ramp in from silence on a constant frame
      s_en = 1'b1;
      repeat (20) frame(1'b1, 32'h40004000, 1'b0);

      // Underruns: silence vs hold-last, dut0 reprimes on the 4th miss
      frame(1'b1, 32'h1234ABCD, 1'b0);
      repeat (4) frame(1'b0, $urandom, 1'b0);
      // dut1's 3-bit counter saturates; dut0 stays in PRIME and does not count
      repeat (5) frame(1'b0, $urandom, 1'b0);
      repeat (3) frame(1'b1, $urandom, 1'b0);
      frame(1'b0, $urandom, 1'b1);

      // Soft mute mid-stream reverses the ramp at the next frame
      repeat (20) frame(1'b1, 32'h80008000, 1'b0);
      s_mute = 1'b1;
      repeat (4) frame(1'b1, 32'h80008000, 1'b0);
      s_mute = 1'b0;
      repeat (6) frame(1'b1, 32'h80008000, 1'b0);

      // Stop ramp down to IDLE, then continuous drain
      s_en = 1'b0;
      repeat (20) frame(1'b1, $urandom, 1'b0);
      repeat (8) step(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0);

      // Randomised traffic
      s_en = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 19) == 0) s_en = !s_en;
         if ($urandom_range(0, 9) == 0) s_mute = !s_mute;
         frame($urandom_range(0, 4) != 0, $urandom, $urandom_range(0, 29) == 0);
      end

      // Reset while running, then restart cleanly
      s_en = 1'b1; s_mute = 1'b0;
      repeat (20) frame(1'b1, $urandom, 1'b0);
      do_reset();
      s_en = 1'b1;
      repeat (6) frame(1'b1, $urandom, 1'b0);

      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
         chk("frames_left", i, 32'(fq[i].size()), 32'h0);
         chk("states_left", i, 32'(sq[i].size()), 32'h0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
